moller_ti_axil_regs: RTL and testbench
======================================

Name: moller_ti_axil_regs

Overview:
AXI4-Lite slave register bank for the MOLLER trigger-interface (TI) IP. It sits directly downstream of the AXI4-Lite master (PS interconnect, or the master VIP in the block-level bench). It exposes four read/write configuration registers to TI fabric logic. It also returns a read-only trigger event counter and a status word to software.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 5, byte address width; covers 0x00-0x1F.
CNT_WIDTH, 32, width of the trigger event counter; must be <= 32.

Ports:
ACLK  in  1  clock; all logic on the rising edge
ARESETN  in  1  asynchronous active-low reset
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write address handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID / S_AXI_WREADY  in/out  1  write data handshake
S_AXI_BRESP  out  2  write response
S_AXI_BVALID / S_AXI_BREADY  out/in  1  write response handshake
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read address handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID / S_AXI_RREADY  out/in  1  read data handshake
trig_in  in  1  single-cycle trigger pulse from TI logic
cfg_reg0..cfg_reg3  out  32 each  live copies of registers 0x00-0x0C

Behaviour:
- Reset (ARESETN low, asynchronous assert, synchronous-release input):
  - All READY/VALID outputs 0; BRESP/RRESP 0; RDATA 0.
  - cfg_reg0..3 are 0; event counter is 0.
- Address map (word-aligned; addr[1:0] ignored):
  - 0x00-0x0C: RW cfg_reg0..3.
  - 0x10: RO event counter, zero-extended to 32 bits.
  - 0x14: RO status. Bit0 = counter saturated; bit1 = trig_in seen since last read of 0x14 (clear-on-read).
  - 0x18, 0x1C: unmapped.
- Write channel FSM, states W_IDLE, W_RESP:
  - In W_IDLE, AWREADY and WREADY are both high.
  - AW and W may arrive in either order or the same cycle. Each is latched independently when its VALID&&READY occurs. Its READY then drops until the transaction completes.
  - When both are latched, the register update happens on that edge, honouring WSTRB per byte. Writes to RO or unmapped addresses are dropped.
  - BVALID rises the next cycle; move to W_RESP.
  - W_RESP: BVALID held, AW/W READY low, until BREADY. Then return to W_IDLE with READY high the following cycle.
  - Best case: AW+W same cycle gives BVALID 1 cycle later.
- Read channel FSM, states R_IDLE, R_DATA:
  - ARREADY is high in R_IDLE.
  - On handshake, RDATA is registered from the decoded address and RVALID rises the next cycle.
  - RDATA/RRESP are held stable while RVALID && !RREADY; ARREADY stays low.
  - Return to R_IDLE on RREADY.
- Simultaneous read and write: the channels are independent. A read issued in the same cycle as a write commit to the same register returns the old value.
- Event counter:
  - Increments on each cycle with trig_in = 1.
  - Saturates at all-ones (no wrap) and sets status bit0.
  - Cleared only by reset, or by a write of any value to 0x14 (status bits also cleared).
- Status bit1:
  - Set by trig_in.
  - Cleared on the RVALID&&RREADY of a 0x14 read.
  - A trig_in in the same cycle wins: the bit stays set.
- BRESP/RRESP are OKAY unless the optional feature is enabled.
- Reset mid-transaction: all state is abandoned and outputs return to reset values immediately.

Optional Feature:
Macro MOLLER_TI_AXIL_SLVERR_EN.
- Defined: accesses to unmapped addresses (0x18, 0x1C) return SLVERR (2'b10) on BRESP/RRESP. Writes to RO 0x10 also return SLVERR. Read data is 0.
- Not defined: all accesses return OKAY; unmapped reads return 0; writes to unmapped or RO addresses are silently dropped. Writes to 0x14 perform the counter clear in both builds.

Test Plan:
- Write 0x1,0x2,0x3,0x4 to 0x00,0x04,0x08,0x0C (WSTRB=0xF), then read back -> RDATA 0x1,0x2,0x3,0x4, RRESP=OKAY; cfg_reg0..3 match.
- AW presented 3 cycles before W; then W before AW; then both same cycle -> each completes exactly once, BVALID 1 cycle after second handshake.
- Write 0xAABBCCDD to 0x04 with WSTRB=0x5 over prior 0x00000002 -> read 0x04 returns 0x00BB00DD.
- Pulse trig_in 5 times -> read 0x10 = 5; read 0x14 = 0x2; read 0x14 again = 0x0.
- Hold BREADY/RREADY low 10 cycles -> BVALID/RVALID and data held stable, no new AW/AR accepted.
- Read 0x18 -> RRESP=SLVERR with MOLLER_TI_AXIL_SLVERR_EN, OKAY/0 without.
- Assert ARESETN low mid-write (AW latched, W pending) -> all outputs 0; a new write after release completes normally.

Source files
------------

// File: rtl/moller_ti_axil_regs.sv
// AXI4-Lite register bank for the MOLLER TI: four RW config registers, a saturating trigger
// counter and a status word. Optional macro MOLLER_TI_AXIL_SLVERR_EN returns SLVERR on bad accesses.
module moller_ti_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH          = 32
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0]                    S_AXI_ARPROT,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  input  logic                          trig_in,
  output logic [C_S_AXI_DATA_WIDTH-1:0] cfg_reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0] cfg_reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0] cfg_reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0] cfg_reg3
);
  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state;
  r_state_t r_state;

  logic [C_S_AXI_DATA_WIDTH-1:0] cfg [4];
  logic [CNT_WIDTH-1:0]          cnt;
  logic                          cnt_sat;
  logic                          seen;

  logic                          aw_got, w_got, rd_status;
  logic [2:0]                    aw_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q;
  logic [3:0]                    wstrb_q;

  logic                          aw_hs, w_hs, wr_commit, cnt_clr, rd_clr, wr_err, rd_err;
  logic [2:0]                    wr_idx, rd_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] wr_data, rd_mux;
  logic [3:0]                    wr_strb;
  logic                          unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // A beat arriving this cycle is merged with whatever half was latched earlier.
  assign aw_hs     = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs      = S_AXI_WVALID && S_AXI_WREADY;
  assign wr_idx    = aw_hs ? S_AXI_AWADDR[4:2] : aw_idx;
  assign wr_data   = w_hs ? S_AXI_WDATA : wdata_q;
  assign wr_strb   = w_hs ? S_AXI_WSTRB : wstrb_q;
  assign wr_commit = (w_state == W_IDLE) && (aw_got || aw_hs) && (w_got || w_hs);
  assign cnt_clr   = wr_commit && (wr_idx == 3'd5);
  assign cnt_sat   = &cnt;
  assign rd_idx    = S_AXI_ARADDR[4:2];
  assign rd_clr    = S_AXI_RVALID && S_AXI_RREADY && rd_status;

  assign cfg_reg0 = cfg[0];
  assign cfg_reg1 = cfg[1];
  assign cfg_reg2 = cfg[2];
  assign cfg_reg3 = cfg[3];

  always_comb begin
    rd_mux = '0;
    case (rd_idx)
      3'd0, 3'd1, 3'd2, 3'd3: rd_mux = cfg[rd_idx[1:0]];
      3'd4:    rd_mux[CNT_WIDTH-1:0] = cnt;
      3'd5:    rd_mux[1:0] = {seen, cnt_sat};
      default: rd_mux = '0;
    endcase
  end

`ifdef MOLLER_TI_AXIL_SLVERR_EN
  assign wr_err = (wr_idx == 3'd4) || (wr_idx == 3'd6) || (wr_idx == 3'd7);
  assign rd_err = (rd_idx == 3'd6) || (rd_idx == 3'd7);
`else
  assign wr_err = 1'b0;
  assign rd_err = 1'b0;
`endif

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state       <= W_IDLE;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= 2'b00;
      aw_got        <= 1'b0;
      w_got         <= 1'b0;
      aw_idx        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) aw_idx <= S_AXI_AWADDR[4:2];
          if (w_hs) begin
            wdata_q <= S_AXI_WDATA;
            wstrb_q <= S_AXI_WSTRB;
          end
          if (wr_commit) begin
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            aw_got        <= 1'b0;
            w_got         <= 1'b0;
            S_AXI_BVALID  <= 1'b1;
            S_AXI_BRESP   <= wr_err ? 2'b10 : 2'b00;
            w_state       <= W_RESP;
          end else begin
            aw_got        <= aw_got || aw_hs;
            w_got         <= w_got || w_hs;
            S_AXI_AWREADY <= !(aw_got || aw_hs);
            S_AXI_WREADY  <= !(w_got || w_hs);
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= 2'b00;
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < 4; i++) cfg[i] <= '0;
    end else if (wr_commit && !wr_idx[2]) begin
      for (int b = 0; b < 4; b++)
        if (wr_strb[b]) cfg[wr_idx[1:0]][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  // Counter clear on a 0x14 write takes priority over a coincident trigger.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cnt  <= '0;
      seen <= 1'b0;
    end else begin
      if (cnt_clr)                 cnt <= '0;
      else if (trig_in && !cnt_sat) cnt <= cnt + 1'b1;
      if (cnt_clr)      seen <= 1'b0;
      else if (trig_in) seen <= 1'b1;
      else if (rd_clr)  seen <= 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state       <= R_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= 2'b00;
      rd_status     <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (S_AXI_ARVALID && S_AXI_ARREADY) begin
            S_AXI_RDATA   <= rd_mux;
            S_AXI_RRESP   <= rd_err ? 2'b10 : 2'b00;
            S_AXI_RVALID  <= 1'b1;
            S_AXI_ARREADY <= 1'b0;
            rd_status     <= (rd_idx == 3'd5);
            r_state       <= R_DATA;
          end else begin
            S_AXI_ARREADY <= 1'b1;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            S_AXI_RVALID  <= 1'b0;
            S_AXI_ARREADY <= 1'b1;
            rd_status     <= 1'b0;
            r_state       <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_moller_ti_axil_regs.sv
// Bench for moller_ti_axil_regs: directed AXI4-Lite sequences plus a randomized phase,
// all checked against a register-map reference model (counter width 4 so saturation is reachable).
module tb_moller_ti_axil_regs;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [4:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [4:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic        trig_in;
  logic [31:0] cfg_reg0, cfg_reg1, cfg_reg2, cfg_reg3;

  moller_ti_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5), .CNT_WIDTH(CW)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .trig_in(trig_in),
    .cfg_reg0(cfg_reg0), .cfg_reg1(cfg_reg1), .cfg_reg2(cfg_reg2), .cfg_reg3(cfg_reg3)
  );

  // clock / reset
  always #5 ACLK = ~ACLK;

  // reference model: plain register-map state
  logic [31:0] m_cfg [4];
  int          m_cnt;
  bit          m_seen;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_cfg[i] = '0;
    m_cnt  = 0;
    m_seen = 0;
  endtask

  function automatic logic [31:0] exp_rdata(input int idx);
    case (idx)
      0, 1, 2, 3: return m_cfg[idx];
      4:          return 32'(m_cnt);
      5:          return {30'd0, m_seen, (m_cnt == CMAX)};
      default:    return 32'd0;
    endcase
  endfunction

  function automatic logic [1:0] exp_rresp(input int idx);
`ifdef MOLLER_TI_AXIL_SLVERR_EN
    return (idx >= 6) ? 2'b10 : 2'b00;
`else
    return 2'b00;
`endif
  endfunction

  function automatic logic [1:0] exp_bresp(input int idx);
`ifdef MOLLER_TI_AXIL_SLVERR_EN
    return (idx == 4 || idx >= 6) ? 2'b10 : 2'b00;
`else
    return 2'b00;
`endif
  endfunction

  task automatic check_cfg_outputs();
    check("cfg_reg0", cfg_reg0, m_cfg[0]);
    check("cfg_reg1", cfg_reg1, m_cfg[1]);
    check("cfg_reg2", cfg_reg2, m_cfg[2]);
    check("cfg_reg3", cfg_reg3, m_cfg[3]);
  endtask

  // driver: AW starts at cycle aw_t, W at cycle w_t; BREADY withheld for bhold cycles
  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_t, input int w_t, input int bhold);
    bit aw_done = 0, w_done = 0, aw_fire, w_fire;
    int cyc = 0;
    int idx = int'(addr[4:2]);
    while (!(aw_done && w_done) && cyc < 40) begin
      @(negedge ACLK);
      if (aw_done) S_AXI_AWVALID = 1'b0;
      else if (cyc >= aw_t) begin S_AXI_AWVALID = 1'b1; S_AXI_AWADDR = addr; end
      if (w_done) S_AXI_WVALID = 1'b0;
      else if (cyc >= w_t) begin S_AXI_WVALID = 1'b1; S_AXI_WDATA = data; S_AXI_WSTRB = strb; end
      aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
      w_fire  = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge ACLK);
      if (aw_fire) aw_done = 1;
      if (w_fire)  w_done = 1;
      cyc++;
    end
    check("wr_handshake_done", {31'd0, aw_done && w_done}, 32'd1);
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    if (idx < 4) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) m_cfg[idx][8*b +: 8] = data[8*b +: 8];
    end else if (idx == 5) begin
      m_cnt  = 0;
      m_seen = 0;
    end
    check("bvalid_latency", {31'd0, S_AXI_BVALID}, 32'd1);
    check("bresp", {30'd0, S_AXI_BRESP}, {30'd0, exp_bresp(idx)});
    check("awready_low_in_resp", {31'd0, S_AXI_AWREADY | S_AXI_WREADY}, 32'd0);
    for (int i = 0; i < bhold; i++) begin
      @(negedge ACLK);
      check("bvalid_held", {31'd0, S_AXI_BVALID}, 32'd1);
      check("bresp_held", {30'd0, S_AXI_BRESP}, {30'd0, exp_bresp(idx)});
      check("aw_blocked", {31'd0, S_AXI_AWREADY | S_AXI_WREADY}, 32'd0);
    end
    S_AXI_BREADY = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
    check("bvalid_cleared", {31'd0, S_AXI_BVALID}, 32'd0);
    check("ready_after_b", {30'd0, S_AXI_AWREADY, S_AXI_WREADY}, 32'd3);
    check_cfg_outputs();
  endtask

  // driver: read with RREADY withheld for hold cycles
  task automatic axi_read(input logic [4:0] addr, input int hold);
    int cyc = 0;
    int idx = int'(addr[4:2]);
    logic [31:0] ed = exp_rdata(idx);
    logic [1:0]  er = exp_rresp(idx);
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b1;
    S_AXI_ARADDR  = addr;
    while (!S_AXI_ARREADY && cyc < 20) begin
      @(negedge ACLK);
      cyc++;
    end
    check("arready_wait", {31'd0, cyc < 20}, 32'd1);
    @(posedge ACLK);
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
    check("rvalid", {31'd0, S_AXI_RVALID}, 32'd1);
    check("rdata", S_AXI_RDATA, ed);
    check("rresp", {30'd0, S_AXI_RRESP}, {30'd0, er});
    for (int i = 0; i < hold; i++) begin
      @(negedge ACLK);
      check("rvalid_held", {31'd0, S_AXI_RVALID}, 32'd1);
      check("rdata_held", S_AXI_RDATA, ed);
      check("ar_blocked", {31'd0, S_AXI_ARREADY}, 32'd0);
    end
    S_AXI_RREADY = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    S_AXI_RREADY = 1'b0;
    check("rvalid_cleared", {31'd0, S_AXI_RVALID}, 32'd0);
    if (idx == 5) m_seen = 0;
  endtask

  task automatic pulse_trig(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge ACLK);
      trig_in = 1'b1;
      if (m_cnt < CMAX) m_cnt++;
      m_seen = 1;
      @(negedge ACLK);
      trig_in = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge ACLK);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_readies"}, {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'd0);
    check({tag, "_valids"}, {30'd0, S_AXI_BVALID, S_AXI_RVALID}, 32'd0);
    check({tag, "_resps"}, {28'd0, S_AXI_BRESP, S_AXI_RRESP}, 32'd0);
    check({tag, "_rdata"}, S_AXI_RDATA, 32'd0);
    check_cfg_outputs();
  endtask

  initial begin
    ARESETN = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 0; S_AXI_BREADY = 0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
    trig_in = 0;
    model_reset();
    repeat (3) @(negedge ACLK);
    check_reset_outputs("reset");
    ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);

    // basic register writes and readback
    axi_write(5'h00, 32'h1, 4'hF, 0, 0, 0);
    axi_write(5'h04, 32'h2, 4'hF, 0, 0, 0);
    axi_write(5'h08, 32'h3, 4'hF, 0, 0, 0);
    axi_write(5'h0C, 32'h4, 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) axi_read(5'(i * 4), 0);

    // channel ordering: AW first, W first, together
    axi_write(5'h08, 32'h1111_2222, 4'hF, 0, 3, 0);
    axi_write(5'h0C, 32'h3333_4444, 4'hF, 3, 0, 0);
    axi_write(5'h00, 32'h5555_6666, 4'hF, 0, 0, 0);

    // byte strobes over 0x00000002 at 0x04
    axi_write(5'h04, 32'hAABB_CCDD, 4'h5, 0, 0, 0);
    axi_read(5'h04, 0);
    check("wstrb_merge", m_cfg[1], 32'h00BB_00DD);

    // counter and clear-on-read status
    axi_write(5'h14, 32'h0, 4'hF, 0, 0, 0);
    pulse_trig(5);
    axi_read(5'h10, 0);
    axi_read(5'h14, 0);
    axi_read(5'h14, 0);

    // backpressure, unmapped read, RO write
    axi_write(5'h0C, 32'hDEAD_BEEF, 4'hF, 1, 0, 10);
    axi_read(5'h0C, 10);
    axi_read(5'h18, 0);
    axi_read(5'h1C, 1);
    axi_write(5'h10, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    axi_read(5'h10, 0);

    // saturation then clear by write to 0x14
    pulse_trig(CMAX + 4);
    axi_read(5'h10, 0);
    axi_read(5'h14, 0);
    axi_write(5'h14, 32'h1234, 4'h1, 0, 0, 0);
    axi_read(5'h10, 0);
    axi_read(5'h14, 0);

    // randomized mix
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 2))
        0: axi_write(5'($urandom_range(0, 7) * 4 + $urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)),
                     $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
        1: axi_read(5'($urandom_range(0, 7) * 4 + $urandom_range(0, 3)), $urandom_range(0, 2));
        default: pulse_trig($urandom_range(1, 6));
      endcase
    end

    // reset mid-write: AW latched, W never presented
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b1;
    S_AXI_AWADDR  = 5'h00;
    @(posedge ACLK);
    #2;
    S_AXI_AWVALID = 1'b0;
    ARESETN = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("midreset");
    @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);
    axi_read(5'h10, 0);
    axi_write(5'h00, 32'hCAFE_F00D, 4'hF, 0, 0, 0);
    axi_read(5'h00, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
